// File: rtl/hlsm_pkg.sv
// Shared types and defaults for the HLSM job sequencer wrapper.
package hlsm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StResp
  } state_e;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefZWidth    = 8;
  localparam int unsigned DefTimeout   = 255;

  function automatic int unsigned timer_width(int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/hlsm_job_sequencer_if.sv
// Operand, HLSM and result handshake signals of the job sequencer.
interface hlsm_job_sequencer_if
  import hlsm_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned ZWidth    = DefZWidth
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DataWidth-1:0] in_a;
  logic [DataWidth-1:0] in_b;
  logic [DataWidth-1:0] in_c;
  logic [DataWidth-1:0] hls_a;
  logic [DataWidth-1:0] hls_b;
  logic [DataWidth-1:0] hls_c;
  logic                 hls_start;
  logic                 hls_done;
  logic [ZWidth-1:0]    hls_z;
  logic [DataWidth-1:0] hls_x;
  logic                 out_valid;
  logic                 out_ready;
  logic [ZWidth-1:0]    out_z;
  logic [DataWidth-1:0] out_x;
  logic                 out_err;
  logic [7:0]           job_cnt;

  modport slave (
    input  in_valid, in_a, in_b, in_c, hls_done, hls_z, hls_x, out_ready,
    output in_ready, hls_a, hls_b, hls_c, hls_start, out_valid, out_z, out_x, out_err, job_cnt
  );

  modport master (
    output in_valid, in_a, in_b, in_c, hls_done, hls_z, hls_x, out_ready,
    input  in_ready, hls_a, hls_b, hls_c, hls_start, out_valid, out_z, out_x, out_err, job_cnt
  );
endinterface

// File: rtl/hlsm_timeout_counter.sv
// WAIT-state cycle timer; expire_o flags the last permitted cycle (Timeout-1).
module hlsm_timeout_counter
  import hlsm_pkg::*;
#(
  parameter int unsigned Timeout = DefTimeout
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int unsigned TimerW = timer_width(Timeout);

  logic [TimerW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TimerW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == TimerW'(Timeout - 1));
endmodule

// File: rtl/hlsm_job_sequencer.sv
// Serialises operand triplets into HLSM, waits for Done with a timeout and
// holds the result until the consumer drains it.
module hlsm_job_sequencer
  import hlsm_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned ZWidth    = DefZWidth,
  parameter int unsigned Timeout   = DefTimeout
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  hlsm_job_sequencer_if.slave  seq_io
);
  state_e               state_q, state_d;
  logic                 in_ready_q, hls_start_q, out_valid_q, out_err_q;
  logic [DataWidth-1:0] hls_a_q, hls_b_q, hls_c_q, out_x_q;
  logic [ZWidth-1:0]    out_z_q;
  logic [7:0]           job_cnt_q;
  logic                 accept, drain, expire;

  hlsm_timeout_counter #(
    .Timeout (Timeout)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (state_q == StStart),
    .en_i     (state_q == StWait),
    .expire_o (expire)
  );

  // in_ready_q is only high in StIdle, so it alone qualifies the accept.
  assign accept = seq_io.in_valid & in_ready_q;
  assign drain  = (state_q == StResp) & seq_io.out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StStart;
      StStart: state_d = StWait;
      StWait:  if (seq_io.hls_done || expire) state_d = StResp;
      StResp:  if (seq_io.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      hls_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_z_q     <= '0;
      out_x_q     <= '0;
      hls_a_q     <= '0;
      hls_b_q     <= '0;
      hls_c_q     <= '0;
      job_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      // Status flags decode the next state so every output leaves a flop.
      in_ready_q  <= (state_d == StIdle);
      hls_start_q <= (state_d == StStart);
      out_valid_q <= (state_d == StResp);
      if (accept) begin
        hls_a_q <= seq_io.in_a;
        hls_b_q <= seq_io.in_b;
        hls_c_q <= seq_io.in_c;
      end
      if (state_q == StWait) begin
        if (seq_io.hls_done) begin
          out_z_q   <= seq_io.hls_z;
          out_x_q   <= seq_io.hls_x;
          out_err_q <= 1'b0;
        end else if (expire) begin
          out_z_q   <= '0;
          out_x_q   <= '0;
          out_err_q <= 1'b1;
        end
      end
      if (drain) begin
        job_cnt_q <= job_cnt_q + 8'd1;
      end
    end
  end

  assign seq_io.in_ready  = in_ready_q;
  assign seq_io.hls_start = hls_start_q;
  assign seq_io.hls_a     = hls_a_q;
  assign seq_io.hls_b     = hls_b_q;
  assign seq_io.hls_c     = hls_c_q;
  assign seq_io.out_valid = out_valid_q;
  assign seq_io.out_z     = out_z_q;
  assign seq_io.out_x     = out_x_q;
  assign seq_io.out_err   = out_err_q;
  assign seq_io.job_cnt   = job_cnt_q;
endmodule
